mem_lane_serializer: RTL

Sits directly downstream of the memory coalescer's output request/response port. It takes one multi-lane request (NUM_LANES line-sized lanes plus a lane mask) and issues the active lanes one per cycle on a single-lane memory port, lowest lane first. Single-lane responses are returned upstream as partial-mask responses, one lane at a time. The coalescer already tracks per-lane completion, so no response reassembly happens here.

---
 rtl/mem_lane_serializer.sv | 106 ++++++++++
 1 files changed

// File: rtl/mem_lane_serializer.sv
// Serializes one multi-lane memory request onto a single-lane port, lowest active lane first,
// and fans single-lane responses back out as one-hot partial-mask responses.
module mem_lane_serializer #(
  parameter int NUM_LANES     = 4,
  parameter int ADDR_WIDTH    = 26,
  parameter int FLAGS_WIDTH   = 1,
  parameter int DATA_SIZE     = 64,
  parameter int DATA_WIDTH    = DATA_SIZE * 8,
  parameter int TAG_WIDTH     = 8,
  parameter int LANE_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  parameter int OUT_TAG_WIDTH = TAG_WIDTH + LANE_W
) (
  input  logic                               clk,
  input  logic                               reset,

  input  logic                               in_req_valid,
  input  logic                               in_req_rw,
  input  logic [NUM_LANES-1:0]               in_req_mask,
  input  logic [NUM_LANES*DATA_SIZE-1:0]     in_req_byteen,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]    in_req_addr,
  input  logic [NUM_LANES*FLAGS_WIDTH-1:0]   in_req_flags,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]    in_req_data,
  input  logic [TAG_WIDTH-1:0]               in_req_tag,
  output logic                               in_req_ready,

  output logic                               in_rsp_valid,
  output logic [NUM_LANES-1:0]               in_rsp_mask,
  output logic [NUM_LANES*DATA_WIDTH-1:0]    in_rsp_data,
  output logic [TAG_WIDTH-1:0]               in_rsp_tag,
  input  logic                               in_rsp_ready,

  output logic                               out_req_valid,
  output logic                               out_req_rw,
  output logic [DATA_SIZE-1:0]               out_req_byteen,
  output logic [ADDR_WIDTH-1:0]              out_req_addr,
  output logic [FLAGS_WIDTH-1:0]             out_req_flags,
  output logic [DATA_WIDTH-1:0]              out_req_data,
  output logic [OUT_TAG_WIDTH-1:0]           out_req_tag,
  input  logic                               out_req_ready,

  input  logic                               out_rsp_valid,
  input  logic [DATA_WIDTH-1:0]              out_rsp_data,
  input  logic [OUT_TAG_WIDTH-1:0]           out_rsp_tag,
  output logic                               out_rsp_ready
);

  logic [NUM_LANES-1:0] rem_mask;
  logic [NUM_LANES-1:0] pending;
  logic [LANE_W-1:0]    lane_idx;
  logic                 found;
  logic                 any_pending;
  logic                 is_last;
  logic                 req_fire;

  assign pending     = in_req_mask & rem_mask;
  assign any_pending = |pending;
  // Clearing the lowest set bit leaves zero exactly when at most one lane remains.
  assign is_last     = (pending & (pending - NUM_LANES'(1))) == '0;

  always_comb begin
    lane_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (pending[i] && !found) begin
        lane_idx = LANE_W'(i);
        found    = 1'b1;
      end
    end
  end

  assign out_req_valid  = in_req_valid & any_pending;
  assign out_req_rw     = in_req_rw;
  assign out_req_byteen = in_req_byteen[lane_idx*DATA_SIZE +: DATA_SIZE];
  assign out_req_addr   = in_req_addr[lane_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign out_req_flags  = in_req_flags[lane_idx*FLAGS_WIDTH +: FLAGS_WIDTH];
  assign out_req_data   = in_req_data[lane_idx*DATA_WIDTH +: DATA_WIDTH];
  assign out_req_tag    = {in_req_tag, lane_idx};

  assign req_fire = out_req_valid & out_req_ready;

  // A zero-mask request has nothing to issue and is consumed immediately.
  assign in_req_ready = (out_req_ready & is_last & any_pending)
                      | (in_req_valid & (in_req_mask == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_mask <= '1;
    end else if (req_fire) begin
      if (is_last) begin
        rem_mask <= '1;
      end else begin
        rem_mask <= rem_mask & ~(NUM_LANES'(1) << lane_idx);
      end
    end
  end

  assign in_rsp_valid  = out_rsp_valid;
  assign out_rsp_ready = in_rsp_ready;
  assign in_rsp_mask   = NUM_LANES'(1) << out_rsp_tag[LANE_W-1:0];
  assign in_rsp_data   = {NUM_LANES{out_rsp_data}};
  assign in_rsp_tag    = out_rsp_tag[OUT_TAG_WIDTH-1:LANE_W];

  zero_mask_req: assert property (@(posedge clk) disable iff (reset)
    in_req_valid |-> (in_req_mask != '0));

endmodule
